// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared word memory.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output mem_addr, mem_write_data, mem_write, mem_read
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  mem_addr, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a shared word memory: data has priority, fetch is forced after STARVE_LIMIT losses.
// Latency: issue in the winning cycle, ack one cycle later; a request is held until its ack (no other backpressure).
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [0:0] S_ARB  = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;
    localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

    logic [0:0]        r_state;
    logic [7:0]        r_starve;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_err;
    logic              r_d_err;

    logic              w_arb;
    logic              w_if_win;
    logic              w_d_win;
    logic [ADDR_W-1:0] w_addr;
    logic              w_aligned;
    logic              w_read;
    logic              w_write;

    assign w_arb     = (r_state == S_ARB);
    assign w_if_win  = w_arb && bus.if_req && (!bus.d_req || (r_starve == LIMIT));
    assign w_d_win   = w_arb && bus.d_req && !w_if_win;
    assign w_addr    = w_if_win ? bus.if_addr : (w_d_win ? bus.d_addr : '0);
    assign w_aligned = (w_addr[1:0] == 2'b00);
    assign w_read    = w_aligned && (w_if_win || (w_d_win && !bus.d_we));
    assign w_write   = w_aligned && w_d_win && bus.d_we;

    assign bus.mem_addr       = w_addr;
    assign bus.mem_read       = w_read;
    // Gated by reset so a store in flight cannot commit on a reset edge.
    assign bus.mem_write      = w_write && rst_n;
    assign bus.mem_write_data = w_write ? bus.d_wdata : '0;

    assign bus.if_ack   = r_if_ack;
    assign bus.if_rdata = r_if_rdata;
    assign bus.if_err   = r_if_err;
    assign bus.d_ack    = r_d_ack;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_err    = r_d_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_ARB;
            r_starve   <= '0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_err   <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            r_if_ack <= w_if_win;
            r_d_ack  <= w_d_win;
            if (w_arb) begin
                // Losses only count while fetch is actually waiting.
                if (w_if_win || !bus.if_req) begin
                    r_starve <= '0;
                end else if (w_d_win && (r_starve != LIMIT)) begin
                    r_starve <= r_starve + 8'd1;
                end
                if (w_if_win) begin
                    r_if_rdata <= w_read ? bus.mem_read_data : '0;
                    r_if_err   <= !w_aligned;
                    r_state    <= S_RESP;
                end
                if (w_d_win) begin
                    r_d_rdata <= w_read ? bus.mem_read_data : '0;
                    r_d_err   <= !w_aligned;
                    r_state   <= S_RESP;
                end
            end else begin
                r_state <= S_ARB;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-memory model and an ack scoreboard.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(18), .DATA_W(32)) bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(18), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.mem_read_data = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.mem_write) wr_cnt++;
        if (rst_n && (bus.if_ack || bus.d_ack)) begin
            chk("single_ack", {31'b0, bus.if_ack & bus.d_ack}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_port", {31'b0, bus.d_ack}, {31'b0, e.port});
                chk("ack_rdata", bus.d_ack ? bus.d_rdata : bus.if_rdata, e.rdata);
                chk("ack_err", {31'b0, bus.d_ack ? bus.d_err : bus.if_err}, {31'b0, e.err});
            end
        end
    end

    function automatic exp_t expect_of(input bit port, input bit we, input logic [17:0] addr,
                                       input logic [31:0] wdata);
        exp_t e;
        bit   al;
        al      = (addr[1:0] == 2'b00);
        e.port  = port;
        e.err   = !al;
        e.rdata = (al && !(port && we)) ? ref_mem[addr[7:2]] : 32'd0;
        if (port && we && al) ref_mem[addr[7:2]] = wdata;
        return e;
    endfunction

    task automatic do_req(input bit port, input bit we, input logic [17:0] addr,
                          input logic [31:0] wdata);
        bit al;
        bit got;
        int lat;
        al = (addr[1:0] == 2'b00);
        @(posedge clk); #1;
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        exp_q.push_back(expect_of(port, we, addr, wdata));
        @(negedge clk);
        chk("issue_addr", {14'b0, bus.mem_addr}, {14'b0, addr});
        chk("issue_read", {31'b0, bus.mem_read}, {31'b0, al && !(port && we)});
        chk("issue_write", {31'b0, bus.mem_write}, {31'b0, al && port && we});
        if (al && port && we) chk("issue_wdata", bus.mem_write_data, wdata);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (port ? bus.d_ack : bus.if_ack) got = 1'b1;
        end
        chk("ack_latency", lat, 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
    endtask

    initial begin
        int acks;
        int wr0;
        int last;
        bit done;

        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acks", {30'b0, bus.if_ack, bus.d_ack}, 32'd0);
        chk("rst_errs", {30'b0, bus.if_err, bus.d_err}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_mem_addr", {14'b0, bus.mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req(1'b0, 1'b0, 18'h14, 32'd0);
        wr0 = wr_cnt;
        do_req(1'b1, 1'b1, 18'h20, 32'h12345678);
        chk("store_one_write", wr_cnt - wr0, 32'd1);
        do_req(1'b1, 1'b0, 18'h20, 32'd0);

        wr0 = wr_cnt;
        do_req(1'b1, 1'b1, 18'h22, 32'hFFFFFFFF);
        chk("misal_no_write", wr_cnt - wr0, 32'd0);
        chk("misal_word8", mem[8], 32'h12345678);
        do_req(1'b0, 1'b0, 18'h13, 32'd0);

        // Both requesters held high: expect four data grants then one fetch, twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(expect_of(1'b1, 1'b0, 18'h20, 32'd0));
            exp_q.push_back(expect_of(1'b0, 1'b0, 18'h14, 32'd0));
        end
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 18'h14;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 18'h20;
        acks = 0;
        for (int i = 0; i < 60 && acks < 10; i++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) acks++;
        end
        chk("contend_acks", acks, 32'd10);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        chk("contend_drained", exp_q.size(), 32'd0);

        // Reset lands on the edge that would commit the store to word 12.
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 18'h30; bus.d_wdata = 32'hCAFEF00D;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_addr", {14'b0, bus.mem_addr}, 32'h30);
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        chk("rstmid_acks", {30'b0, bus.if_ack, bus.d_ack}, 32'd0);
        chk("rstmid_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        chk("rstmid_errs", {30'b0, bus.if_err, bus.d_err}, 32'd0);
        chk("rstmid_strobes", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rstmid_mem_bus", {14'b0, bus.mem_addr} | bus.mem_write_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid_word12", mem[12], 32'd0);

        // Fetch held continuously: ack every second cycle, no read during ack.
        for (int k = 0; k < 4; k++) exp_q.push_back(expect_of(1'b0, 1'b0, 18'h14, 32'd0));
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 18'h14;
        acks = 0;
        last = -1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                chk("b2b_resp_read", {31'b0, bus.mem_read}, 32'd0);
                if (last >= 0) chk("b2b_spacing", i - last, 32'd2);
                last = i;
                acks++;
                if (acks == 4) done = 1'b1;
            end else begin
                chk("b2b_arb_read", {31'b0, bus.mem_read}, 32'd1);
            end
        end
        chk("b2b_acks", acks, 32'd4);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
